// File: rtl/apb_i2c_regbank_if.sv
// APB3 bus bundle between the system bus master and the I2C register bank.
interface apb_i2c_regbank_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_i2c_regbank.sv
// APB3 register bank for the I2C master: decoded map, wait states, FIFO strobes, sticky IRQ flags.
// Optional error responses are enabled with `define APB_I2C_SLVERR_EN.
module apb_i2c_regbank #(
    parameter int         DATA_W       = 8,
    parameter int         ADDR_W       = 3,
    parameter int         WAIT_STATES  = 0,
    parameter logic [7:0] PRESCALE_RST = 8'h04
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_i2c_regbank_if.slave     apb,
    input  logic [7:0]           status_reg,
    input  logic [7:0]           receive_reg,
    output logic [7:0]           transmit_reg,
    output logic                 tx_push,
    output logic                 rx_pop,
    output logic [7:0]           command_reg,
    output logic                 cmd_valid,
    output logic [7:0]           prescale_reg,
    output logic [7:0]           address_reg,
    output logic                 irq
);
    localparam logic [3:0] WAIT_MAX = 4'(WAIT_STATES);

    logic [3:0] wait_cnt;
    logic       access;
    logic       pready;
    logic       commit;
    logic [2:0] idx;
    logic       unmapped;
    logic       wr_commit;
    logic       rd_commit;
    logic [7:0] wdata8;
    logic       tx_full;
    logic       rx_empty;
    logic [3:0] irq_en;
    logic [3:0] irq_stat;
    logic [3:0] irq_set;
    logic [3:0] irq_clr;
    logic       nack_q;
    logic       empty_q;
    logic [7:0] rd_byte;
    logic [DATA_W-1:0] prdata_w;
    logic       unused_ok;

    assign access   = apb.PSELx & apb.PENABLE;
    assign pready   = access & (wait_cnt == WAIT_MAX);
    assign commit   = access & pready;
    assign idx      = apb.PADDR[2:0];
    assign wdata8   = apb.PWDATA[7:0];
    assign tx_full  = status_reg[4];
    assign rx_empty = status_reg[5];

    generate
        if (ADDR_W > 3) begin : g_hi_addr
            assign unmapped = |apb.PADDR[ADDR_W-1:3];
        end else begin : g_no_hi_addr
            assign unmapped = 1'b0;
        end
    endgenerate

    assign wr_commit = commit &  apb.PWRITE & ~unmapped;
    assign rd_commit = commit & ~apb.PWRITE & ~unmapped;
    assign unused_ok = ^{status_reg[3:0], apb.PWDATA};

    // Wait counter restarts on every new access phase and parks at the limit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= 4'd0;
        end else if (!access) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prescale_reg <= PRESCALE_RST;
            command_reg  <= 8'd0;
            address_reg  <= 8'd0;
            transmit_reg <= 8'd0;
            irq_en       <= 4'd0;
        end else if (wr_commit) begin
            case (idx)
                3'd0: prescale_reg <= wdata8;
                3'd1: command_reg  <= wdata8;
                3'd2: address_reg  <= wdata8;
                3'd3: if (!tx_full) transmit_reg <= wdata8;
                3'd6: irq_en       <= wdata8[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_push   <= 1'b0;
            rx_pop    <= 1'b0;
            cmd_valid <= 1'b0;
        end else begin
            tx_push   <= wr_commit & (idx == 3'd3) & ~tx_full;
            rx_pop    <= rd_commit & (idx == 3'd4) & ~rx_empty;
            cmd_valid <= wr_commit & (idx == 3'd1);
        end
    end

    // Sticky event flags; a same-cycle hardware set beats the W1C clear.
    always_comb begin
        irq_set    = 4'd0;
        irq_set[0] = wr_commit & (idx == 3'd3) & tx_full;
        irq_set[1] = rd_commit & (idx == 3'd4) & rx_empty;
        irq_set[2] = status_reg[7] & ~nack_q;
        irq_set[3] = ~rx_empty & empty_q;
        irq_clr    = (wr_commit && idx == 3'd7) ? wdata8[3:0] : 4'd0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_stat <= 4'd0;
            nack_q   <= 1'b0;
            empty_q  <= 1'b1;
            irq      <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~irq_clr) | irq_set;
            nack_q   <= status_reg[7];
            empty_q  <= rx_empty;
            irq      <= |(irq_stat & irq_en);
        end
    end

    always_comb begin
        rd_byte = 8'd0;
        case (idx)
            3'd0: rd_byte = prescale_reg;
            3'd1: rd_byte = command_reg;
            3'd2: rd_byte = address_reg;
            3'd4: rd_byte = rx_empty ? 8'd0 : receive_reg;
            3'd5: rd_byte = {status_reg[7:4], 2'b00, irq_stat[1:0]};
            3'd6: rd_byte = {4'd0, irq_en};
            3'd7: rd_byte = {4'd0, irq_stat};
            default: rd_byte = 8'd0;
        endcase
        prdata_w = '0;
        if (pready && !apb.PWRITE && !unmapped) begin
            prdata_w[7:0] = rd_byte;
        end
    end

    assign apb.PRDATA = prdata_w;
    assign apb.PREADY = pready;

`ifdef APB_I2C_SLVERR_EN
    logic slv_err;

    always_comb begin
        slv_err = unmapped;
        if (apb.PWRITE) begin
            if (idx == 3'd4 || idx == 3'd5) slv_err = 1'b1;
            if (idx == 3'd3 && tx_full)     slv_err = 1'b1;
        end else begin
            if (idx == 3'd3)                slv_err = 1'b1;
            if (idx == 3'd4 && rx_empty)    slv_err = 1'b1;
        end
    end

    assign apb.PSLVERR = commit & slv_err;
`else
    assign apb.PSLVERR = 1'b0;
`endif
endmodule

// File: tb/tb_apb_i2c_regbank.sv
// Directed self-checking bench for apb_i2c_regbank, built with WAIT_STATES=2.
module tb_apb_i2c_regbank;
    logic       PCLK;
    logic       PRESETn;
    logic [7:0] status_reg;
    logic [7:0] receive_reg;
    logic [7:0] transmit_reg;
    logic       tx_push;
    logic       rx_pop;
    logic [7:0] command_reg;
    logic       cmd_valid;
    logic [7:0] prescale_reg;
    logic [7:0] address_reg;
    logic       irq;

    int         num_checks = 0;
    int         num_fail   = 0;
    logic [7:0] rd;
    logic       err;
    int         waits;
    logic       exp_err;

    apb_i2c_regbank_if #(.ADDR_W(3), .DATA_W(8)) apb ();

    apb_i2c_regbank #(
        .DATA_W(8), .ADDR_W(3), .WAIT_STATES(2), .PRESCALE_RST(8'h04)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(apb),
        .status_reg(status_reg), .receive_reg(receive_reg),
        .transmit_reg(transmit_reg), .tx_push(tx_push), .rx_pop(rx_pop),
        .command_reg(command_reg), .cmd_valid(cmd_valid),
        .prescale_reg(prescale_reg), .address_reg(address_reg), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One full APB transfer; returns at #1 after the commit edge with the bus idle.
    task automatic apb_xfer(input logic w, input logic [2:0] a, input logic [7:0] d,
                            output logic [7:0] rdata, output logic slverr, output int nwait);
        @(posedge PCLK); #1;
        apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = w; apb.PADDR = a; apb.PWDATA = d;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        nwait = 0;
        while (!apb.PREADY && nwait < 20) begin
            @(posedge PCLK); #1;
            nwait++;
        end
        if (!apb.PREADY) begin
            nwait = -1;
            num_checks++; num_fail++;
            $display("[TB] FAIL pready_timeout: got PREADY=0 after 20 cycles, required 1");
        end
        rdata  = apb.PRDATA;
        slverr = apb.PSLVERR;
        @(posedge PCLK); #1;
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 3'd0; apb.PWDATA = 8'd0;
        status_reg = 8'h20; receive_reg = 8'h00;
        repeat (3) @(posedge PCLK);
        #1;
        num_checks++;
        if (prescale_reg !== 8'h04) begin num_fail++; $display("[TB] FAIL rst_prescale: got %h required 04", prescale_reg); end
        num_checks++;
        if ({transmit_reg, command_reg, address_reg} !== 24'd0) begin num_fail++; $display("[TB] FAIL rst_regs: got %h required 000000", {transmit_reg, command_reg, address_reg}); end
        num_checks++;
        if ({irq, tx_push, rx_pop, cmd_valid, apb.PREADY} !== 5'b0) begin num_fail++; $display("[TB] FAIL rst_outputs: got %b required 00000", {irq, tx_push, rx_pop, cmd_valid, apb.PREADY}); end
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        apb_xfer(1'b0, 3'd0, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h04) begin num_fail++; $display("[TB] FAIL read_prescale: got %h required 04", rd); end
        apb_xfer(1'b0, 3'd1, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h00) begin num_fail++; $display("[TB] FAIL read_cmd: got %h required 00", rd); end
        num_checks++;
        if ({irq, tx_push, rx_pop, cmd_valid} !== 4'b0) begin num_fail++; $display("[TB] FAIL idle_strobes: got %b required 0000", {irq, tx_push, rx_pop, cmd_valid}); end
    endtask

    task automatic test_tx_write();
        apb_xfer(1'b1, 3'd3, 8'hA5, rd, err, waits);
        num_checks++;
        if (waits !== 2) begin num_fail++; $display("[TB] FAIL wait_states: got %0d required 2", waits); end
        num_checks++;
        if (transmit_reg !== 8'hA5) begin num_fail++; $display("[TB] FAIL tx_data: got %h required a5", transmit_reg); end
        num_checks++;
        if (tx_push !== 1'b1) begin num_fail++; $display("[TB] FAIL tx_push_hi: got %b required 1", tx_push); end
        @(posedge PCLK); #1;
        num_checks++;
        if (tx_push !== 1'b0) begin num_fail++; $display("[TB] FAIL tx_push_lo: got %b required 0", tx_push); end
        apb_xfer(1'b0, 3'd3, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h00) begin num_fail++; $display("[TB] FAIL txdata_reads0: got %h required 00", rd); end
    endtask

    task automatic test_tx_overflow();
        apb_xfer(1'b1, 3'd6, 8'h01, rd, err, waits);
        status_reg = 8'h30;
        apb_xfer(1'b1, 3'd3, 8'h5A, rd, err, waits);
        num_checks++;
        if ({tx_push, transmit_reg} !== {1'b0, 8'hA5}) begin num_fail++; $display("[TB] FAIL ovf_drop: got push=%b data=%h required push=0 data=a5", tx_push, transmit_reg); end
        num_checks++;
        if (irq !== 1'b0) begin num_fail++; $display("[TB] FAIL ovf_irq_lag: got %b required 0", irq); end
        @(posedge PCLK); #1;
        num_checks++;
        if (irq !== 1'b1) begin num_fail++; $display("[TB] FAIL ovf_irq_rise: got %b required 1", irq); end
        apb_xfer(1'b0, 3'd7, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h01) begin num_fail++; $display("[TB] FAIL ovf_stat: got %h required 01", rd); end
        apb_xfer(1'b0, 3'd5, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h31) begin num_fail++; $display("[TB] FAIL status_read: got %h required 31", rd); end
        apb_xfer(1'b1, 3'd7, 8'h01, rd, err, waits);
        @(posedge PCLK); #1;
        num_checks++;
        if (irq !== 1'b0) begin num_fail++; $display("[TB] FAIL w1c_irq_fall: got %b required 0", irq); end
        status_reg = 8'h20;
    endtask

    task automatic test_rx_read();
        receive_reg = 8'h3C;
        status_reg  = 8'h00;
        apb_xfer(1'b0, 3'd4, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h3C) begin num_fail++; $display("[TB] FAIL rx_data: got %h required 3c", rd); end
        num_checks++;
        if (rx_pop !== 1'b1) begin num_fail++; $display("[TB] FAIL rx_pop_hi: got %b required 1", rx_pop); end
        @(posedge PCLK); #1;
        num_checks++;
        if (rx_pop !== 1'b0) begin num_fail++; $display("[TB] FAIL rx_pop_lo: got %b required 0", rx_pop); end
        status_reg = 8'h20;
        apb_xfer(1'b0, 3'd4, 8'h00, rd, err, waits);
        num_checks++;
        if ({rd, rx_pop} !== 9'd0) begin num_fail++; $display("[TB] FAIL rx_empty_read: got data=%h pop=%b required data=00 pop=0", rd, rx_pop); end
        apb_xfer(1'b0, 3'd7, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h0A) begin num_fail++; $display("[TB] FAIL rx_stat: got %h required 0a", rd); end
        num_checks++;
        if (irq !== 1'b0) begin num_fail++; $display("[TB] FAIL rx_irq_masked: got %b required 0", irq); end
        apb_xfer(1'b1, 3'd7, 8'h0F, rd, err, waits);
        apb_xfer(1'b0, 3'd7, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h00) begin num_fail++; $display("[TB] FAIL w1c_all: got %h required 00", rd); end
    endtask

    task automatic test_cmd_addr();
        apb_xfer(1'b1, 3'd1, 8'h81, rd, err, waits);
        num_checks++;
        if ({cmd_valid, command_reg} !== {1'b1, 8'h81}) begin num_fail++; $display("[TB] FAIL cmd_write: got valid=%b cmd=%h required valid=1 cmd=81", cmd_valid, command_reg); end
        @(posedge PCLK); #1;
        num_checks++;
        if (cmd_valid !== 1'b0) begin num_fail++; $display("[TB] FAIL cmd_valid_lo: got %b required 0", cmd_valid); end
        apb_xfer(1'b1, 3'd2, 8'hA1, rd, err, waits);
        apb_xfer(1'b0, 3'd2, 8'h00, rd, err, waits);
        num_checks++;
        if ({rd, address_reg} !== 16'hA1A1) begin num_fail++; $display("[TB] FAIL addr_rw: got rd=%h reg=%h required a1 a1", rd, address_reg); end
        apb_xfer(1'b1, 3'd0, 8'h10, rd, err, waits);
        num_checks++;
        if (prescale_reg !== 8'h10) begin num_fail++; $display("[TB] FAIL prescale_write: got %h required 10", prescale_reg); end
        apb_xfer(1'b1, 3'd6, 8'hFF, rd, err, waits);
        apb_xfer(1'b0, 3'd6, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h0F) begin num_fail++; $display("[TB] FAIL irq_en_width: got %h required 0f", rd); end
        apb_xfer(1'b1, 3'd6, 8'h01, rd, err, waits);
    endtask

    task automatic test_w1c_set_wins();
        int n;
        status_reg = 8'hA0;
        @(posedge PCLK); #1;
        status_reg = 8'h20;
        apb_xfer(1'b0, 3'd7, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h04) begin num_fail++; $display("[TB] FAIL nack_edge: got %h required 04", rd); end
        @(posedge PCLK); #1;
        apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 3'd7; apb.PWDATA = 8'h04;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        n = 0;
        while (!apb.PREADY && n < 20) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (!apb.PREADY) begin
            num_checks++; num_fail++;
            $display("[TB] FAIL set_wins_timeout: got PREADY=0 required 1");
        end
        status_reg = 8'hA0;
        @(posedge PCLK); #1;
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
        apb_xfer(1'b0, 3'd7, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h04) begin num_fail++; $display("[TB] FAIL set_wins: got %h required 04", rd); end
        apb_xfer(1'b1, 3'd7, 8'h04, rd, err, waits);
        apb_xfer(1'b0, 3'd7, 8'h00, rd, err, waits);
        num_checks++;
        if (rd !== 8'h00) begin num_fail++; $display("[TB] FAIL w1c_bit2: got %h required 00", rd); end
        status_reg = 8'h20;
    endtask

    task automatic test_slverr();
`ifdef APB_I2C_SLVERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        apb_xfer(1'b1, 3'd5, 8'hFF, rd, err, waits);
        num_checks++;
        if (err !== exp_err) begin num_fail++; $display("[TB] FAIL slverr_ro_write: got %b required %b", err, exp_err); end
        apb_xfer(1'b0, 3'd5, 8'h00, rd, err, waits);
        num_checks++;
        if ({rd, err} !== 9'h040) begin num_fail++; $display("[TB] FAIL status_unchanged: got rd=%h err=%b required 20 0", rd, err); end
        apb_xfer(1'b0, 3'd3, 8'h00, rd, err, waits);
        num_checks++;
        if (err !== exp_err) begin num_fail++; $display("[TB] FAIL slverr_wo_read: got %b required %b", err, exp_err); end
    endtask

    task automatic test_wait_abort();
        @(posedge PCLK); #1;
        apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 3'd0; apb.PWDATA = 8'h55;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        num_checks++;
        if (apb.PREADY !== 1'b0) begin num_fail++; $display("[TB] FAIL abort_pready: got %b required 0", apb.PREADY); end
        @(posedge PCLK); #1;
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        num_checks++;
        if (prescale_reg !== 8'h10) begin num_fail++; $display("[TB] FAIL abort_no_commit: got %h required 10", prescale_reg); end
        apb_xfer(1'b0, 3'd0, 8'h00, rd, err, waits);
        num_checks++;
        if ({waits[3:0], rd} !== {4'd2, 8'h10}) begin num_fail++; $display("[TB] FAIL abort_recover: got waits=%0d rd=%h required 2 10", waits, rd); end
    endtask

    task automatic test_reset_mid();
        apb_xfer(1'b1, 3'd3, 8'h77, rd, err, waits);
        num_checks++;
        if (tx_push !== 1'b1) begin num_fail++; $display("[TB] FAIL pre_reset_push: got %b required 1", tx_push); end
        PRESETn = 1'b0;
        #1;
        num_checks++;
        if ({tx_push, transmit_reg, prescale_reg} !== {1'b0, 8'h00, 8'h04}) begin num_fail++; $display("[TB] FAIL async_reset: got push=%b tx=%h pre=%h required 0 00 04", tx_push, transmit_reg, prescale_reg); end
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_tx_write();
        test_tx_overflow();
        test_rx_read();
        test_cmd_addr();
        test_w1c_set_wins();
        test_slverr();
        test_wait_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end
endmodule

// File: doc/apb_i2c_regbank.md
Name: apb_i2c_regbank

Overview:
Parametrised APB3 slave register bank for the I2C master. It replaces the fixed-width, single-address APB front end with a decoded register map and programmable wait states. It adds single-pulse TX push / RX pop handshakes toward the I2C core's FIFOs, sticky error flags, and a maskable interrupt. It sits between the system APB bus and the I2C byte controller/FIFOs.

Parameters:
DATA_W, 8, APB data width; register fields occupy bits [7:0], bits above 7 read 0 and ignore writes.
ADDR_W, 3, PADDR width; register index = PADDR[2:0], any higher PADDR bits nonzero = unmapped.
WAIT_STATES, 0, extra access-phase cycles before PREADY (0..15).
PRESCALE_RST, 8'h04, reset value of PRESCALE.

Ports:
PCLK  in  1  clock
PRESETn  in  1  async active-low reset
PSELx  in  1  APB select
PENABLE  in  1  APB enable (access phase)
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_W  register address
PWDATA  in  DATA_W  write data
PRDATA  out  DATA_W  read data, valid when PREADY=1 in access phase, else 0
PREADY  out  1  transfer complete
PSLVERR  out  1  error response (see Optional Feature)
status_reg  in  8  core status: [7] nack, [6] bus busy, [5] rx empty, [4] tx full
receive_reg  in  8  RX FIFO head byte
transmit_reg  out  8  byte for TX FIFO, valid with tx_push
tx_push  out  1  one-cycle TX FIFO write strobe
rx_pop  out  1  one-cycle RX FIFO read strobe
command_reg  out  8  command register
cmd_valid  out  1  one-cycle pulse after CMD write
prescale_reg  out  8  SCL prescaler
address_reg  out  8  {7-bit slave addr, R/W}
irq  out  1  registered interrupt

Behaviour:
- Reset (PRESETn=0, async): transmit_reg=0, command_reg=0, address_reg=0, prescale_reg=PRESCALE_RST, IRQ_EN=0, IRQ_STAT=0, all strobes 0, irq=0, wait counter=0.
- Wait counter: cleared whenever !(PSELx&PENABLE); increments during access phase, saturating at WAIT_STATES. PREADY = PSELx & PENABLE & (count==WAIT_STATES). WAIT_STATES=0 gives zero-wait APB.
- Commit cycle = PSELx&PENABLE&PREADY. All register updates and side effects happen exactly once, on the commit cycle. Strobes (tx_push, rx_pop, cmd_valid) are registered: high on the cycle after commit, for one cycle.
- Map (index): 0 PRESCALE RW; 1 CMD RW (write also pulses cmd_valid); 2 ADDR RW; 3 TXDATA WO (reads 0); 4 RXDATA RO; 5 STATUS RO = {status_reg[7:4], 2'b0, IRQ_STAT[1:0]}; 6 IRQ_EN RW [3:0]; 7 IRQ_STAT W1C [3:0].
- TXDATA write: if status_reg[4]=0, then transmit_reg<=PWDATA[7:0] and tx_push pulses. If full, data is dropped, no push, and IRQ_STAT[0] (tx overflow) is set.
- RXDATA read: if status_reg[5]=0, PRDATA=receive_reg and rx_pop pulses. If empty, PRDATA=0, no pop, and IRQ_STAT[1] (rx underflow) is set.
- Other IRQ_STAT events: [2] rising edge of status_reg[7] (nack); [3] falling edge of status_reg[5] (rx data arrived). Edge detectors hold the previous sample; their reset value is nack=0, empty=1.
- W1C: bits written 1 clear. A hardware set and a W1C clear on the same bit in the same cycle leaves the bit set (set wins).
- irq <= |(IRQ_STAT & IRQ_EN), registered, so it lags the flag by one cycle.
- Writes to RO registers and reads of WO registers have no side effect. Unmapped addresses read 0 and write nothing.
- PSELx dropped mid-wait: counter clears, nothing commits.
- Reset asserted mid-transfer: everything returns to reset values immediately; pending strobes are cancelled.

Optional Feature:
APB_I2C_SLVERR_EN: when defined, PSLVERR=1 during the commit cycle for any of: unmapped address, write to RO (4,5), read of WO (3), TXDATA write while full, RXDATA read while empty. The side-effect rules above still apply. When undefined, PSLVERR is tied to 0.

Test Plan:
- Reset, then read idx0, idx1 -> PRDATA 8'h04 then 8'h00. irq=0, no strobes.
- WAIT_STATES=2, write 8'hA5 to idx3 with full=0 -> PREADY high on 3rd access cycle, transmit_reg=8'hA5, tx_push high exactly one cycle after commit.
- Write idx3 with full=1 -> no tx_push, IRQ_STAT=4'b0001. With IRQ_EN=4'h1, irq rises one cycle later. W1C 8'h01 -> irq falls.
- receive_reg=8'h3C, empty=0, read idx4 -> PRDATA 8'h3C, one rx_pop. Repeat with empty=1 -> PRDATA 0, IRQ_STAT[1]=1.
- status_reg[7] 0->1 on the same cycle as a W1C of bit2 -> bit2 remains 1.
- With APB_I2C_SLVERR_EN, write PADDR=3'd5 -> PSLVERR=1 on the commit cycle and STATUS is unchanged. Without the macro -> PSLVERR=0.
